// File: rtl/issue_station.sv
// In-order micro-op issue queue between decode and the regfile/ALU.
// Decoded ops are buffered in a DEPTH-entry ring. The oldest unissued op drives
// the regfile read addresses each cycle. Its control fields reach the ALU stage
// one cycle later, aligned with alu_a/alu_b. An op retires only after a clean
// ALU cycle. A flag-write conflict rewinds issue to the oldest unretired op, so
// the failed op and every younger op are replayed in order.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every queued and in-flight op
//   id_valid/id_ready decode handshake; id_* carry the op fields
//   r_a_addr/r_b_addr/r_pc  read-stage addresses (combinational, 0 when idle)
//   ex_valid, ex_op, alu_d_adr, alu_d_wr, alu_sf_wr  ALU-stage control
//   conflict_sf       regfile reports the ALU flag write was lost this cycle
module issue_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OPW   = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           id_valid,
    output logic           id_ready,
    input  logic [OPW-1:0] id_op,
    input  logic [2:0]     id_a,
    input  logic [2:0]     id_b,
    input  logic [2:0]     id_d,
    input  logic           id_dwr,
    input  logic           id_sfwr,
    input  logic [15:0]    id_pc,
    output logic [2:0]     r_a_addr,
    output logic [2:0]     r_b_addr,
    output logic [15:0]    r_pc,
    output logic           ex_valid,
    output logic [OPW-1:0] ex_op,
    output logic [2:0]     alu_d_adr,
    output logic           alu_d_wr,
    output logic           alu_sf_wr,
    input  logic           conflict_sf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [2:0]     a;
        logic [2:0]     b;
        logic [2:0]     d;
        logic           dwr;
        logic           sfwr;
        logic [15:0]    pc;
    } uop_t;

    uop_t          mem [DEPTH];
    uop_t          iss_e;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] iss_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          full;
    logic          enq;
    logic          can_issue;
    logic          rewind;
    logic          retire;
    logic          fire;
    logic          ex_dwr;
    logic          ex_sfwr;

    // Occupancy from registered pointers; the extra MSB separates full from empty.
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == PW'(DEPTH));
    assign id_ready  = ~full & ~rst;
    assign enq       = id_valid & id_ready & ~flush;

    assign can_issue = (iss_ptr != wr_ptr);
    assign rewind    = ex_valid & conflict_sf;
    assign retire    = ex_valid & ~conflict_sf;
    assign fire      = can_issue & ~rewind & ~flush;
    assign iss_e     = mem[iss_ptr[AW-1:0]];

    // Read-stage addresses; the regfile samples them at the next edge.
    always_comb begin
        r_a_addr = '0;
        r_b_addr = '0;
        r_pc     = '0;
        if (can_issue) begin
            r_a_addr = iss_e.a;
            r_b_addr = iss_e.b;
            r_pc     = iss_e.pc;
        end
    end

    assign alu_d_wr  = ex_valid & ex_dwr;
    assign alu_sf_wr = ex_valid & ex_sfwr;

    // Ring storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr[AW-1:0]] <= '{op: id_op, a: id_a, b: id_b, d: id_d,
                                     dwr: id_dwr, sfwr: id_sfwr, pc: id_pc};
        end
    end

    // Pointers and ALU-stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            iss_ptr   <= '0;
            rd_ptr    <= '0;
            ex_valid  <= 1'b0;
            ex_op     <= '0;
            alu_d_adr <= '0;
            ex_dwr    <= 1'b0;
            ex_sfwr   <= 1'b0;
        end else if (flush) begin
            // Collapse the ring to empty at the write pointer.
            iss_ptr  <= wr_ptr;
            rd_ptr   <= wr_ptr;
            ex_valid <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Failed op is the oldest unretired one, so replay restarts at rd_ptr.
            if (rewind) begin
                iss_ptr <= rd_ptr;
            end else if (fire) begin
                iss_ptr <= iss_ptr + PW'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            ex_valid <= fire;
            if (fire) begin
                ex_op     <= iss_e.op;
                alu_d_adr <= iss_e.d;
                ex_dwr    <= iss_e.dwr;
                ex_sfwr   <= iss_e.sfwr;
            end
        end
    end

endmodule

// File: tb/tb_issue_station.sv
// Bench for issue_station: queue-level reference model checked every cycle,
// a retire-order scoreboard, and directed scenarios with literal expectations.
module tb_issue_station;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned OPW   = 5;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [2:0]     a;
        logic [2:0]     b;
        logic [2:0]     d;
        logic           dwr;
        logic           sfwr;
        logic [15:0]    pc;
    } uop_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           id_valid;
    logic           id_ready;
    logic [OPW-1:0] id_op;
    logic [2:0]     id_a;
    logic [2:0]     id_b;
    logic [2:0]     id_d;
    logic           id_dwr;
    logic           id_sfwr;
    logic [15:0]    id_pc;
    logic [2:0]     r_a_addr;
    logic [2:0]     r_b_addr;
    logic [15:0]    r_pc;
    logic           ex_valid;
    logic [OPW-1:0] ex_op;
    logic [2:0]     alu_d_adr;
    logic           alu_d_wr;
    logic           alu_sf_wr;
    logic           conflict_sf;

    issue_station #(.DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_op(id_op), .id_a(id_a), .id_b(id_b), .id_d(id_d),
        .id_dwr(id_dwr), .id_sfwr(id_sfwr), .id_pc(id_pc),
        .r_a_addr(r_a_addr), .r_b_addr(r_b_addr), .r_pc(r_pc),
        .ex_valid(ex_valid), .ex_op(ex_op), .alu_d_adr(alu_d_adr),
        .alu_d_wr(alu_d_wr), .alu_sf_wr(alu_sf_wr),
        .conflict_sf(conflict_sf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: list of unretired ops (oldest first), how many of them
    // have been sent to the ALU, and the op currently in the ALU stage.
    uop_t mq[$];
    uop_t sb[$];
    int   nis   = 0;
    bit   mex_v = 1'b0;
    uop_t mex   = '0;
    int   nret  = 0;

    always @(negedge clk) begin
        bit   ci;
        bit   rew;
        bit   ret;
        bit   fire;
        bit   acc;
        uop_t cur;
        ci = (nis < mq.size());
        chk("id_ready",  id_ready,  32'((!rst) && (mq.size() < DEPTH)));
        chk("ex_valid",  ex_valid,  32'(mex_v));
        chk("r_a_addr",  r_a_addr,  ci ? 32'(mq[nis].a)  : 32'd0);
        chk("r_b_addr",  r_b_addr,  ci ? 32'(mq[nis].b)  : 32'd0);
        chk("r_pc",      r_pc,      ci ? 32'(mq[nis].pc) : 32'd0);
        chk("alu_d_wr",  alu_d_wr,  32'(mex_v & mex.dwr));
        chk("alu_sf_wr", alu_sf_wr, 32'(mex_v & mex.sfwr));
        if (mex_v) begin
            chk("ex_op",     ex_op,     32'(mex.op));
            chk("alu_d_adr", alu_d_adr, 32'(mex.d));
        end
        // Retire order must equal acceptance order.
        if (!rst && !flush && ex_valid && !conflict_sf) begin
            nret++;
            if (sb.size() == 0) begin
                chk("retire_extra", 32'd1, 32'd0);
            end else begin
                chk("retire_order", ex_op, 32'(sb[0].op));
                void'(sb.pop_front());
            end
        end
        cur = '{op: id_op, a: id_a, b: id_b, d: id_d, dwr: id_dwr, sfwr: id_sfwr, pc: id_pc};
        if (rst) begin
            mq.delete(); sb.delete();
            nis = 0; mex_v = 1'b0; mex = '0;
        end else if (flush) begin
            mq.delete(); sb.delete();
            nis = 0; mex_v = 1'b0;
        end else begin
            rew  = mex_v && conflict_sf;
            ret  = mex_v && !conflict_sf;
            fire = ci && !rew;
            acc  = id_valid && (mq.size() < DEPTH);
            if (fire) begin
                mex = mq[nis];
                nis++;
            end
            mex_v = fire;
            if (ret) begin
                void'(mq.pop_front());
                nis--;
            end
            if (rew) nis = 0;
            if (acc) begin
                mq.push_back(cur);
                sb.push_back(cur);
            end
        end
    end

    uop_t pend[$];

    function automatic uop_t mk(input int op, input int a, input int b, input int d,
                                input bit dwr, input bit sfwr, input int pc);
        return '{op: OPW'(op), a: 3'(a), b: 3'(b), d: 3'(d), dwr: dwr, sfwr: sfwr, pc: 16'(pc)};
    endfunction

    // One clock: drive inputs, then return 1 time unit after the next rising edge.
    task automatic cyc(input bit offer, input bit cf, input bit fl);
        bit acc;
        id_valid    = offer && (pend.size() > 0);
        if (pend.size() > 0) begin
            {id_op, id_a, id_b, id_d, id_dwr, id_sfwr, id_pc} = pend[0];
        end
        conflict_sf = cf;
        flush       = fl;
        #1;
        acc = id_valid && id_ready && !fl;
        @(posedge clk);
        #1;
        if (acc) void'(pend.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  reps;
        int  base;
        bit  done;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; conflict_sf = 1'b0;
        id_op = '0; id_a = '0; id_b = '0; id_d = '0; id_dwr = 1'b0; id_sfwr = 1'b0; id_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_ready", id_ready, 32'd0);
        chk("rst_ex_op",    ex_op,    32'd0);
        chk("rst_alu_dadr", alu_d_adr, 32'd0);
        chk("rst_r_a_addr", r_a_addr, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", id_ready, 32'd1);

        // Back-to-back A then B, no bubbles.
        pend.push_back(mk(1, 1, 2, 4, 1, 0, 100));
        pend.push_back(mk(2, 4, 5, 6, 0, 0, 101));
        cyc(1, 0, 0);
        chk("t1_ra_T", r_a_addr, 32'd1);
        cyc(1, 0, 0);
        chk("t1_exv_A",  ex_valid,  32'd1);
        chk("t1_dadr_A", alu_d_adr, 32'd4);
        chk("t1_dwr_A",  alu_d_wr,  32'd1);
        chk("t1_ra_T1",  r_a_addr,  32'd4);
        cyc(0, 0, 0);
        chk("t1_exv_B", ex_valid, 32'd1);
        chk("t1_op_B",  ex_op,    32'd2);
        chk("t1_dwr_B", alu_d_wr, 32'd0);
        repeat (3) cyc(0, 0, 0);
        chk("t1_idle", ex_valid, 32'd0);

        // Fill while the flag-writing head op keeps failing.
        pend.push_back(mk(3, 1, 1, 1, 0, 1, 200));
        for (int i = 4; i < 8; i++) pend.push_back(mk(i, i, i, i, 1, 0, 200 + i));
        repeat (8) cyc(1, 1, 0);
        chk("t2_full_ready", id_ready, 32'd0);
        chk("t2_fifth_wait", 32'(pend.size()), 32'd1);
        for (int i = 0; i < 20 && pend.size() > 0; i++) cyc(1, 0, 0);
        chk("t2_fifth_taken", 32'(pend.size()), 32'd0);
        repeat (8) cyc(0, 0, 0);

        // A fails three times in a row; B must follow it, once.
        pend.push_back(mk(8, 3, 2, 1, 0, 1, 300));
        pend.push_back(mk(9, 5, 6, 2, 1, 0, 301));
        reps = 0;
        for (int i = 0; i < 20; i++) begin
            bit cf;
            cf = ex_valid && (ex_op == 5'd8) && (reps < 3);
            if (cf) reps++;
            cyc(1, cf, 0);
            if (cf) begin
                chk("t3_bubble", ex_valid, 32'd0);
                chk("t3_reread", r_a_addr, 32'd3);
            end
        end
        chk("t4_replays", 32'(reps), 32'd3);

        // Flush a full queue with the head op in flight.
        pend.push_back(mk(10, 1, 2, 3, 1, 1, 400));
        for (int i = 11; i < 14; i++) pend.push_back(mk(i, 7, 6, 5, 1, 0, 400 + i));
        repeat (6) cyc(1, 1, 0);
        chk("t5_full", id_ready, 32'd0);
        pend.push_back(mk(14, 2, 2, 2, 1, 0, 414));
        cyc(1, 0, 1);
        chk("t5_exv",   ex_valid, 32'd0);
        chk("t5_ready", id_ready, 32'd1);
        chk("t5_ra",    r_a_addr, 32'd0);
        repeat (6) cyc(1, 0, 0);

        // Random stream of 20 ops with random stalls and conflicts.
        base = nret;
        for (int i = 0; i < 20; i++) begin
            pend.push_back(mk(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1000 + i));
        end
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            cyc($urandom_range(0, 3) != 0, ex_valid && ($urandom_range(0, 3) == 0), 0);
            done = (pend.size() == 0) && (mq.size() == 0);
        end
        chk("t6_drained", 32'(done), 32'd1);
        chk("t6_retired", 32'(nret - base), 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
